apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Single-outstanding APB requester that turns a valid/ready command into a standard two-phase APB transfer (SETUP, then ACCESS).
- Returns the read data and error status on a valid/ready response channel.
- Sits between a local controller and APB completers such as the 64-byte register map at base 0x1000_2000.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 32, width of all data buses
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort (used only with the optional feature)

Ports:
pclk  in  1  clock, rising edge
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
cmd_addr  in  ADDR_W  byte address
cmd_write  in  1  1 = write, 0 = read
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high
rsp_rdata  out  DATA_W  read data (0 for writes and for errors)
rsp_err  out  1  pslverr, misalignment or timeout
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data (0 for reads)
pready  in  1  completer ready
prdata  in  DATA_W  completer read data
pslverr  in  1  completer error
busy  out  1  state is not IDLE

Behaviour:
- Reset values: all outputs except cmd_ready are 0, state is IDLE. cmd_ready reads 1 while presetn is high and the state is IDLE.
- Asserting presetn low asynchronously forces IDLE and clears all registers, including mid-transfer: psel and penable drop immediately and any pending response is discarded.
- All APB outputs and rsp_* are registered. cmd_ready = (state == IDLE), combinational from the state register.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE, on accept with cmd_addr[1:0] == 0:
  - latch paddr, pwrite, pwdata (pwdata = cmd_wdata for a write, 0 for a read)
  - psel <= 1, penable <= 0
  - go to SETUP
- IDLE, on accept with cmd_addr[1:0] != 0 (misaligned):
  - no APB activity; psel stays 0
  - rsp_err <= 1, rsp_rdata <= 0, rsp_valid <= 1
  - go to RESP
- SETUP: lasts exactly one cycle. penable <= 1, go to ACCESS. paddr, pwrite and pwdata stay stable.
- ACCESS, pready low: hold every APB output unchanged (wait state).
- ACCESS, pready high (prdata and pslverr are sampled only in this cycle):
  - rsp_rdata <= (read && !pslverr) ? prdata : 0
  - rsp_err <= pslverr
  - rsp_valid <= 1
  - psel, penable, pwdata <= 0
  - go to RESP
- RESP: rsp_valid and its data are held until rsp_ready is high. On that cycle, rsp_valid <= 0, rsp_err <= 0, go to IDLE. rsp_ready high in the same cycle rsp_valid first rises counts as consumption on the next edge.
- Latency, zero-wait aligned transfer:
  - accept edge (A): psel rises
  - A+1: penable rises
  - A+2: pready sampled high
  - A+3: rsp_valid is high
  - minimum 4 cycles per command, including the return through IDLE
- cmd_valid is ignored outside IDLE; commands are never queued.
- paddr is held after the transfer and is don't-care while psel is 0.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - a counter clears on entry to ACCESS and increments on each ACCESS cycle with pready low
  - when it reaches TIMEOUT_CYCLES, the transfer aborts: psel, penable <= 0, rsp_err <= 1, rsp_rdata <= 0, go to RESP
  - pready high on the same edge the count reaches TIMEOUT_CYCLES wins (normal completion)
  - counter width is $clog2(TIMEOUT_CYCLES+1)
- Undefined: no counter; ACCESS waits for pready indefinitely.

Test Plan:
- Write 0x1000_2004 / 0xDEADBEEF, pready tied 1 → psel rises at A, penable at A+1, deasserted after A+2; rsp_valid at A+3 with err 0, rdata 0; pwdata 0xDEADBEEF throughout.
- Read 0x1000_2008, pready low 3 ACCESS cycles then high with prdata 0x12345678 (garbage prdata beforehand) → APB signals stable through wait states; rsp_rdata 0x12345678, err 0.
- Read with pslverr 1 and prdata 0xFFFF_FFFF on the pready cycle → rsp_err 1, rsp_rdata 0.
- Command at 0x1000_2002 → psel never asserts; rsp_valid one cycle after accept with err 1; cmd_ready 0 until the response is consumed.
- rsp_ready held low 5 cycles, with cmd_valid high throughout → rsp_valid and data stable, cmd_ready 0, no second psel; after rsp_ready, the next command starts.
- presetn pulsed low during ACCESS → psel, penable, busy 0 immediately with no response; with APB_MASTER_TIMEOUT_EN and pready stuck 0 → abort after 16 wait cycles with rsp_err 1.

Source files
------------

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready to APB requester
// Optional abort of stalled transfers is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // A zero timeout would abort every transfer before it could complete
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            r_state;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_aligned;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_next;
  assign w_to_next = r_to_cnt + TO_W'(1);
`endif

  assign w_aligned = (cmd_addr[1:0] == 2'b00);
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Transfer FSM: IDLE -> SETUP -> ACCESS (wait on pready) -> RESP -> IDLE
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_aligned) begin
              r_paddr   <= cmd_addr;
              r_pwrite  <= cmd_write;
              r_pwdata  <= cmd_write ? cmd_wdata : '0;
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
              r_state   <= S_SETUP;
            end else begin
              // Misaligned: answer immediately without touching the bus
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          r_to_cnt  <= '0;
`endif
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            r_rsp_rdata <= (!r_pwrite && !pslverr) ? prdata : '0;
            r_rsp_err   <= pslverr;
            r_rsp_valid <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwdata    <= '0;
            r_state     <= S_RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (w_to_next == TO_LIMIT) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwdata    <= '0;
            r_state     <= S_RESP;
          end else begin
            r_to_cnt <= w_to_next;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
